// File: rtl/ascon_pkg.sv
// ascon_pkg: constants, phase encoding and helpers shared by the Ascon-128 encrypt and decrypt cores.
package ascon_pkg;

  localparam logic [63:0] IV_128 = 64'h80400c0600000000;
  localparam logic [63:0] PAD    = 64'h8000000000000000;

  // pa uses entries 0..11, pb uses the last six (6..11)
  localparam logic [7:0] RC [12] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  // column S-box, index bit 4 is word x0
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  typedef enum logic [2:0] {IDLE, INIT, ADB, ADP, MSG, FIN, DONE} phase_e;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// ascon_round: one combinational Ascon permutation round (constant, S-box layer, linear diffusion).
module ascon_round
  import ascon_pkg::*;
(
  input  logic [319:0] s_i,
  input  logic [3:0]   idx,
  output logic [319:0] s_o
);

  logic [63:0] x [5];
  logic [63:0] y [5];
  logic [4:0]  col;

  always_comb begin
    col = '0;
    s_o = '0;
    for (int w = 0; w < 5; w++) begin
      x[w] = s_i[319-64*w -: 64] ^ ((w == 2) ? {56'd0, RC[idx]} : 64'd0);
      y[w] = '0;
    end
    for (int b = 0; b < 64; b++) begin
      col = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
      for (int w = 0; w < 5; w++) y[w][b] = col[4-w];
    end
    for (int w = 0; w < 5; w++)
      s_o[319-64*w -: 64] = y[w] ^ ror64(y[w], ROT_A[w]) ^ ror64(y[w], ROT_B[w]);
  end

endmodule

// File: rtl/decrypt_1block_128.sv
// decrypt_1block_128: iterative Ascon-128 decryption of one AD block and one ciphertext block.
// Plaintext is released only when the recomputed tag matches the received one.
module decrypt_1block_128
  import ascon_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] SK,
  input  logic [127:0] N,
  input  logic [63:0]  A,
  input  logic [63:0]  C,
  input  logic [127:0] T,
  output logic [63:0]  P,
  output logic         auth_ok,
  output logic         busy,
  output logic         done
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 3 && UNROLL != 6) begin : g_bad_unroll
    $error("UNROLL must be 1, 2, 3 or 6");
  end

  phase_e       phase_q, phase_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [319:0] s_q, s_d;
  logic [127:0] sk_q, sk_d, t_q, t_d, tc_q, tc_d;
  logic [63:0]  a_q, a_d, c_q, c_d, pt_q, pt_d, p_q, p_d;
  logic         ok_q, ok_d, busy_q, busy_d, done_q, done_d;
  logic [319:0] chain [UNROLL+1];
  logic [319:0] perm, mix;
  logic         short_ph, last;

  assign chain[0] = s_q;
  assign short_ph = phase_q == ADB || phase_q == ADP || phase_q == MSG;

  for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
    ascon_round u_round (
      .s_i (chain[g]),
      .idx (rnd_q + (short_ph ? 4'd6 : 4'd0) + 4'(g)),
      .s_o (chain[g+1])
    );
  end

  assign perm = chain[UNROLL];
  assign last = (rnd_q + 4'(UNROLL)) == (short_ph ? 4'd6 : 4'd12);

  // state injections applied on the edge that completes each phase
  assign mix = phase_q == INIT ? perm ^ {a_q, 128'd0, sk_q} :
               phase_q == ADB  ? perm ^ {PAD, 256'd0} :
               phase_q == ADP  ? {c_q, perm[255:1], ~perm[0]} :
               phase_q == MSG  ? perm ^ {PAD, sk_q, 128'd0} : perm;

  always_comb begin
    phase_d = phase_q;
    rnd_d   = rnd_q;
    s_d     = s_q;
    sk_d    = sk_q;
    a_d     = a_q;
    c_d     = c_q;
    t_d     = t_q;
    tc_d    = tc_q;
    pt_d    = pt_q;
    p_d     = p_q;
    ok_d    = ok_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (phase_q == IDLE) begin
      if (start) begin
        sk_d    = SK;
        a_d     = A;
        c_d     = C;
        t_d     = T;
        s_d     = {IV_128, SK, N};
        rnd_d   = '0;
        p_d     = '0;
        ok_d    = 1'b0;
        busy_d  = 1'b1;
        phase_d = INIT;
      end
    end else if (phase_q == DONE) begin
      ok_d    = tc_q == t_q;
      p_d     = (tc_q == t_q) ? pt_q : '0;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      phase_d = IDLE;
    end else begin
      s_d     = last ? mix : perm;
      rnd_d   = last ? 4'd0 : rnd_q + 4'(UNROLL);
      phase_d = last ? phase_e'(phase_q + 3'd1) : phase_q;
      pt_d    = (last && phase_q == ADP) ? perm[319:256] ^ c_q : pt_q;
      tc_d    = (last && phase_q == FIN) ? perm[127:0] ^ sk_q : tc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= IDLE;
      rnd_q   <= '0;
      s_q     <= '0;
      sk_q    <= '0;
      a_q     <= '0;
      c_q     <= '0;
      t_q     <= '0;
      tc_q    <= '0;
      pt_q    <= '0;
      p_q     <= '0;
      ok_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      rnd_q   <= rnd_d;
      s_q     <= s_d;
      sk_q    <= sk_d;
      a_q     <= a_d;
      c_q     <= c_d;
      t_q     <= t_d;
      tc_q    <= tc_d;
      pt_q    <= pt_d;
      p_q     <= p_d;
      ok_q    <= ok_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign P       = p_q;
  assign auth_ok = ok_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
